// File: rtl/spi_bridge_pkg.sv
// Shared constants, FSM state type and helpers for the SPI-to-memory command bridge.
package spi_bridge_pkg;

    // Command words seen on the SPI link
    localparam logic [7:0]  OP_REG_RD_HI = 8'h80;
    localparam logic [15:0] OP_MEM_RD    = 16'hC000;
    localparam logic [15:0] OP_MEM_WR    = 16'hC100;
    localparam logic [15:0] WORD_FILLER  = 16'h0000;

    // Register map addresses
    localparam logic [7:0] REG_ID     = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h01;
    localparam logic [7:0] REG_RDDATA = 8'h04;

    // Command decoder states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_LO = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_DATA    = 3'd3,
        ST_ISSUE   = 3'd4
    } state_t;

    // Increment an 8-bit counter, sticking at all-ones
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_bridge_regfile.sv
// Register file of the bridge: read mux, last read data, read status flags
// and the saturating dropped-word counter.
module spi_bridge_regfile
    import spi_bridge_pkg::*;
#(
    parameter logic [15:0] ID_VALUE = 16'h5A01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        busy,
    input  logic        issue_active,
    input  logic        rd_issue,
    input  logic        rd_ready,
    input  logic [15:0] rd_data,
    input  logic        drop_inc,
    input  logic        reg_rd,
    input  logic [7:0]  reg_addr,
    output logic [15:0] reg_rdata
);

    logic [15:0] reg4_r;
    logic        read_pending_r;
    logic        rd_done_r;
    logic [7:0]  drop_cnt_r;
    logic        capture_s;

    assign capture_s = rd_ready & read_pending_r;

    // Read mux; returns pre-edge values so a same-cycle capture is not visible yet
    always_comb begin
        reg_rdata = 16'h0000;
        case (reg_addr)
            REG_ID:     reg_rdata = ID_VALUE;
            REG_STATUS: reg_rdata = {drop_cnt_r, 4'b0000, issue_active, rd_done_r,
                                     read_pending_r, busy};
            REG_RDDATA: reg_rdata = reg4_r;
            default:    reg_rdata = 16'h0000;
        endcase
    end

    // Capture of returned read data; only a read this bridge issued is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg4_r <= 16'h0000;
        end else if (capture_s) begin
            reg4_r <= rd_data;
        end else begin
            reg4_r <= reg4_r;
        end
    end

    // Outstanding-read flag: set by a new read request, cleared by its data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_pending_r <= 1'b0;
        end else if (rd_issue) begin
            read_pending_r <= 1'b1;
        end else if (capture_s) begin
            read_pending_r <= 1'b0;
        end else begin
            read_pending_r <= read_pending_r;
        end
    end

    // Read-done flag: capture beats a simultaneous host read of the data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_done_r <= 1'b0;
        end else if (rd_issue) begin
            rd_done_r <= 1'b0;
        end else if (capture_s) begin
            rd_done_r <= 1'b1;
        end else if (reg_rd && (reg_addr == REG_RDDATA)) begin
            rd_done_r <= 1'b0;
        end else begin
            rd_done_r <= rd_done_r;
        end
    end

    // Count of discarded words and aborted commands, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'h00;
        end else if (drop_inc) begin
            drop_cnt_r <= sat_inc8(drop_cnt_r);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

endmodule

// File: rtl/spi_mem_cmd_bridge.sv
// Decodes 16-bit SPI words into register reads and memory read/write
// requests toward the sdram_controller host port.
module spi_mem_cmd_bridge
    import spi_bridge_pkg::*;
#(
    parameter logic [15:0] ID_VALUE       = 16'h5A01,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter int          ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       rx_word,
    input  logic              rx_valid,
    output logic [15:0]       tx_word,
    output logic              tx_load,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_enable,
    input  logic [15:0]       rd_data,
    input  logic              rd_ready,
    input  logic              busy
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              op_wr_r;
    logic [31:0]       addr_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [15:0]       tx_word_r;
    logic              tx_load_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [15:0]       wr_data_r;
    logic [ADDR_W-1:0] rd_addr_r;

    logic        start_rd_s;
    logic        start_wr_s;
    logic        load_lo_s;
    logic        load_hi_s;
    logic        load_data_s;
    logic        reg_rd_s;
    logic        drop_inc_s;
    logic        issue_s;
    logic        tmo_exp_s;
    logic        in_cmd_s;
    logic [15:0] reg_rdata_s;

    assign tmo_exp_s = (tmo_cnt_r == TMO_LAST);
    assign in_cmd_s  = (state_r == ST_ADDR_LO) || (state_r == ST_ADDR_HI) ||
                       (state_r == ST_DATA);

    // The request strobe must rise in the first non-busy ISSUE cycle, so it is
    // decoded from the state register and busy rather than registered again.
    assign wr_enable = issue_s & op_wr_r;
    assign rd_enable = issue_s & ~op_wr_r;
    assign tx_word   = tx_word_r;
    assign tx_load   = tx_load_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign rd_addr   = rd_addr_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle action strobes
    always_comb begin
        state_nxt_s = state_r;
        start_rd_s  = 1'b0;
        start_wr_s  = 1'b0;
        load_lo_s   = 1'b0;
        load_hi_s   = 1'b0;
        load_data_s = 1'b0;
        reg_rd_s    = 1'b0;
        drop_inc_s  = 1'b0;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_word[15:8] == OP_REG_RD_HI) begin
                        reg_rd_s = 1'b1;
                    end else if (rx_word == OP_MEM_RD) begin
                        start_rd_s  = 1'b1;
                        state_nxt_s = ST_ADDR_LO;
                    end else if (rx_word == OP_MEM_WR) begin
                        start_wr_s  = 1'b1;
                        state_nxt_s = ST_ADDR_LO;
                    end else if (rx_word == WORD_FILLER) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        drop_inc_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR_LO: begin
                if (rx_valid) begin
                    load_lo_s   = 1'b1;
                    state_nxt_s = ST_ADDR_HI;
                end else if (tmo_exp_s) begin
                    drop_inc_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ADDR_LO;
                end
            end
            ST_ADDR_HI: begin
                if (rx_valid) begin
                    load_hi_s   = 1'b1;
                    state_nxt_s = ST_DATA;
                end else if (tmo_exp_s) begin
                    drop_inc_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ADDR_HI;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    load_data_s = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else if (tmo_exp_s) begin
                    drop_inc_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_ISSUE: begin
                if (!busy) begin
                    issue_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
                if (rx_valid) begin
                    drop_inc_s = 1'b1;
                end else begin
                    drop_inc_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Remember whether the command in flight is a write or a read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr_r <= 1'b0;
        end else if (start_wr_s) begin
            op_wr_r <= 1'b1;
        end else if (start_rd_s) begin
            op_wr_r <= 1'b0;
        end else begin
            op_wr_r <= op_wr_r;
        end
    end

    // Address shadow assembled from the two address words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= 32'h0000_0000;
        end else if (load_lo_s) begin
            addr_r <= {addr_r[31:16], rx_word};
        end else if (load_hi_s) begin
            addr_r <= {rx_word, addr_r[15:0]};
        end else begin
            addr_r <= addr_r;
        end
    end

    // Request address/data are loaded before ISSUE so they are stable when the strobe fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_r <= '0;
            wr_data_r <= 16'h0000;
            rd_addr_r <= '0;
        end else if (load_data_s && op_wr_r) begin
            wr_addr_r <= ADDR_W'(addr_r);
            wr_data_r <= rx_word;
        end else if (load_data_s) begin
            rd_addr_r <= ADDR_W'(addr_r);
        end else begin
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
            rd_addr_r <= rd_addr_r;
        end
    end

    // Idle-cycle counter for aborting a stalled command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= '0;
        end else if (rx_valid || !in_cmd_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Reply word and its load pulse for the next SPI exchange
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_word_r <= 16'h0000;
            tx_load_r <= 1'b0;
        end else if (reg_rd_s) begin
            tx_word_r <= reg_rdata_s;
            tx_load_r <= 1'b1;
        end else begin
            tx_word_r <= tx_word_r;
            tx_load_r <= 1'b0;
        end
    end

    spi_bridge_regfile #(
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .busy         (busy),
        .issue_active (state_r == ST_ISSUE),
        .rd_issue     (rd_enable),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .drop_inc     (drop_inc_s),
        .reg_rd       (reg_rd_s),
        .reg_addr     (rx_word[7:0]),
        .reg_rdata    (reg_rdata_s)
    );

endmodule

// File: tb/tb_spi_mem_cmd_bridge.sv
// Randomized scoreboard bench for spi_mem_cmd_bridge.
module tb_spi_mem_cmd_bridge;

    localparam int          TMO = 4096;
    localparam logic [15:0] ID  = 16'h5A01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rx_word = 16'h0000;
    logic        rx_valid = 1'b0;
    logic [15:0] tx_word;
    logic        tx_load;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_enable;
    logic [31:0] rd_addr;
    logic        rd_enable;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_ready = 1'b0;
    logic        busy = 1'b0;

    always #5 clk = ~clk;

    spi_mem_cmd_bridge #(
        .ID_VALUE       (ID),
        .TIMEOUT_CYCLES (TMO),
        .ADDR_W         (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_word   (rx_word),
        .rx_valid  (rx_valid),
        .tx_word   (tx_word),
        .tx_load   (tx_load),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_enable (wr_enable),
        .rd_addr   (rd_addr),
        .rd_enable (rd_enable),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard queues of expected DUT outputs
    logic [15:0] exp_tx[$];
    logic [31:0] exp_wa[$];
    logic [15:0] exp_wd[$];
    logic [31:0] exp_ra[$];

    // Reference model: architectural state of the bridge as seen by the host
    logic [15:0] m_reg4;
    logic [7:0]  m_drop;
    bit          m_pend;
    bit          m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name, input logic [31:0] val);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output pulse with value %h, none expected", name, val);
    endtask

    task automatic model_reset();
        m_reg4 = 16'h0000;
        m_drop = 8'h00;
        m_pend = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_drop();
        if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
    endtask

    function automatic logic [15:0] reg_value(input logic [7:0] a, input logic b);
        if (a == 8'h00) return ID;
        else if (a == 8'h01) return {m_drop, 4'b0000, 1'b0, m_done, m_pend, b};
        else if (a == 8'h04) return m_reg4;
        else return 16'h0000;
    endfunction

    // All driving tasks start and end 1 time unit after a rising edge
    task automatic step(input logic v, input logic [15:0] w, input logic r, input logic [15:0] d);
        rx_valid = v;
        rx_word  = w;
        rd_ready = r;
        rd_data  = d;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [15:0] w);
        step(1'b1, w, 1'b0, 16'h0000);
    endtask

    task automatic reg_read(input logic [7:0] a, input bit with_rdy, input logic [15:0] d);
        logic b;
        bit   cap;
        b = 1'($urandom_range(0, 1));
        busy = b;
        exp_tx.push_back(reg_value(a, b));
        cap = with_rdy && m_pend;
        if (a == 8'h04) m_done = 1'b0;
        if (cap) begin
            m_reg4 = d;
            m_pend = 1'b0;
            m_done = 1'b1;
        end
        step(1'b1, {8'h80, a}, with_rdy, d);
        busy = 1'b0;
        idle(1);
    endtask

    task automatic rdy_pulse(input logic [15:0] d);
        if (m_pend) begin
            m_reg4 = d;
            m_pend = 1'b0;
            m_done = 1'b1;
        end
        step(1'b0, 16'h0000, 1'b1, d);
        idle(1);
    endtask

    function automatic logic [15:0] junk_word();
        logic [15:0] w;
        w = 16'($urandom);
        while (w[15:8] == 8'h80 || w == 16'hC000 || w == 16'hC100 || w == 16'h0000)
            w = 16'($urandom);
        return w;
    endfunction

    task automatic send_junk();
        model_drop();
        send(junk_word());
    endtask

    task automatic mem_cmd(input bit wr, input logic [31:0] a, input logic [15:0] d,
                           input int busy_cyc, input int long_gap);
        if (wr) begin
            exp_wa.push_back(a);
            exp_wd.push_back(d);
        end else begin
            exp_ra.push_back(a);
        end
        send(wr ? 16'hC100 : 16'hC000);
        idle($urandom_range(0, 3));
        send(a[15:0]);
        idle(long_gap > 0 ? long_gap : int'($urandom_range(0, 3)));
        send(a[31:16]);
        idle($urandom_range(0, 3));
        if (busy_cyc > 0) busy = 1'b1;
        send(wr ? d : 16'($urandom));
        if (busy_cyc == 0) begin
            @(negedge clk);
            check("issue_latency", 32'(wr ? wr_enable : rd_enable), 32'd1);
            @(posedge clk); #1;
        end else begin
            idle(busy_cyc / 2);
            model_drop();
            send(16'($urandom));
            idle(busy_cyc - busy_cyc / 2);
            busy = 1'b0;
        end
        idle(2);
        if (!wr) begin
            m_pend = 1'b1;
            m_done = 1'b0;
        end
    endtask

    task automatic reset_and_check(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_tx_word"}, 32'(tx_word), 32'd0);
        check({tag, "_wr_addr"}, wr_addr, 32'd0);
        check({tag, "_rd_addr"}, rd_addr, 32'd0);
        check({tag, "_strobes"}, 32'({tx_load, wr_enable, rd_enable, |wr_data}), 32'd0);
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_load) begin
                if (exp_tx.size() == 0) spurious("tx_load", 32'(tx_word));
                else check("tx_word", 32'(tx_word), 32'(exp_tx.pop_front()));
            end
            if (wr_enable) begin
                check("wr_en_busy", 32'(busy), 32'd0);
                if (exp_wa.size() == 0) begin
                    spurious("wr_enable", wr_addr);
                end else begin
                    check("wr_addr", wr_addr, exp_wa.pop_front());
                    check("wr_data", 32'(wr_data), 32'(exp_wd.pop_front()));
                end
            end
            if (rd_enable) begin
                check("rd_en_busy", 32'(busy), 32'd0);
                if (exp_ra.size() == 0) spurious("rd_enable", rd_addr);
                else check("rd_addr", rd_addr, exp_ra.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        reset_and_check("reset0");

        // Identification register
        reg_read(8'h00, 1'b0, 16'h0000);

        // Directed writes and a read at address 10
        mem_cmd(1'b1, 32'h0000_0000, 16'hABCD, 0, 0);
        mem_cmd(1'b1, 32'h0000_000A, 16'hEF01, 0, 0);
        mem_cmd(1'b0, 32'h0000_000A, 16'h0000, 0, 0);
        reg_read(8'h01, 1'b0, 16'h0000);
        rdy_pulse(16'hEF01);
        reg_read(8'h01, 1'b0, 16'h0000);
        reg_read(8'h04, 1'b0, 16'h0000);
        reg_read(8'h01, 1'b0, 16'h0000);

        // Busy held during ISSUE with a word dropped meanwhile
        mem_cmd(1'b1, $urandom, 16'($urandom), 50, 0);
        reg_read(8'h01, 1'b0, 16'h0000);

        // Longest gap that must not abort a command
        mem_cmd(1'b1, $urandom, 16'($urandom), 0, TMO - 1);

        // Stalled command aborts, then an unknown word in IDLE
        send(16'hC100);
        send(16'h0001);
        idle(TMO + 2);
        model_drop();
        reg_read(8'h01, 1'b0, 16'h0000);
        send(16'h9100);
        model_drop();
        idle(1);
        reg_read(8'h01, 1'b0, 16'h0000);

        // Register read of reg4 in the same cycle as read-data capture
        mem_cmd(1'b0, $urandom, 16'h0000, 0, 0);
        reg_read(8'h04, 1'b1, 16'h1357);
        reg_read(8'h01, 1'b0, 16'h0000);
        reg_read(8'h04, 1'b0, 16'h0000);

        // Randomized mix of transactions
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 6))
                0: reg_read(8'($urandom), 1'b0, 16'h0000);
                1: reg_read(($urandom_range(0, 1) == 0) ? 8'h01 : 8'h04, 1'b0, 16'h0000);
                2: mem_cmd(1'b1, $urandom, 16'($urandom),
                           ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 12)), 0);
                3: mem_cmd(1'b0, $urandom, 16'h0000,
                           ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 12)), 0);
                4: rdy_pulse(16'($urandom));
                5: send_junk();
                default: send(16'h0000);
            endcase
        end
        reg_read(8'h01, 1'b0, 16'h0000);

        // Drop counter saturation
        repeat (260) send_junk();
        idle(1);
        reg_read(8'h01, 1'b0, 16'h0000);

        // Reset in the middle of a command (ADDR_HI)
        send(16'hC000);
        send(16'h1234);
        reset_and_check("reset_addr_hi");
        reg_read(8'h01, 1'b0, 16'h0000);

        // Reset while a read is pending; a later rd_ready must be ignored
        mem_cmd(1'b0, $urandom, 16'h0000, 0, 0);
        reset_and_check("reset_pending");
        rdy_pulse(16'h4321);
        reg_read(8'h04, 1'b0, 16'h0000);
        reg_read(8'h01, 1'b0, 16'h0000);

        idle(10);
        check("tx_left", 32'(exp_tx.size()), 32'd0);
        check("wr_left", 32'(exp_wa.size()), 32'd0);
        check("rd_left", 32'(exp_ra.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
